// File: rtl/regfile_wb_queue.sv
// Write-back FIFO in front of the register file write port, with operand forwarding.
// Forwarding compare logic exists only when REGFILE_WBQ_FWD_EN is defined.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [ADDR_W-1:0]          wb_rd,
  input  logic [DATA_W-1:0]          wb_data,
  output logic                       RegWrite,
  output logic [ADDR_W-1:0]          WriteRegNum,
  output logic [DATA_W-1:0]          WriteRegData,
  input  logic [ADDR_W-1:0]          fwd_rs1,
  input  logic [ADDR_W-1:0]          fwd_rs2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [DATA_W-1:0]          fwd_data1,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic              full;

  assign full     = (count == CW'(DEPTH));
  assign wb_ready = !full;
  // x0 writes are handshaken but never stored
  assign push     = wb_valid && wb_ready && (wb_rd != '0);
  assign pop      = (count != '0);
  assign pending  = pop || RegWrite;

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr]   <= wb_rd;
      data_q[wr_ptr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite     <= 1'b0;
      WriteRegNum  <= '0;
      WriteRegData <= '0;
    end else begin
      RegWrite <= pop;
      if (pop) begin
        WriteRegNum  <= rd_q[rd_ptr];
        WriteRegData <= data_q[rd_ptr];
      end
    end
  end

`ifdef REGFILE_WBQ_FWD_EN
  // Walk oldest to youngest so the youngest match overrides earlier ones.
  function automatic logic [DATA_W:0] lookup(
    input logic [ADDR_W-1:0] rs
  );
    logic [DATA_W:0] r;
    logic [PW-1:0]   idx;
    r = '0;
    if (rs != '0) begin
      if (RegWrite && WriteRegNum == rs)
        r = {1'b1, WriteRegData};
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if (CW'(i) < count && rd_q[idx] == rs)
          r = {1'b1, data_q[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = lookup(fwd_rs1);
    {fwd_hit2, fwd_data2} = lookup(fwd_rs2);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rs1, fwd_rs2};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue against a queue-based reference model.
// Forwarding expectations follow REGFILE_WBQ_FWD_EN.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        RegWrite;
  logic [4:0]  WriteRegNum;
  logic [31:0] WriteRegData;
  logic [4:0]  fwd_rs1 = '0;
  logic [4:0]  fwd_rs2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  count;
  logic        pending;

  regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .RegWrite(RegWrite), .WriteRegNum(WriteRegNum),
    .WriteRegData(WriteRegData),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .pending(pending)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 0;
  ent_t mq[$];
  ent_t exp_q[$];
  bit   ov = 0;
  ent_t oreg = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
`ifdef REGFILE_WBQ_FWD_EN
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rd == rs) return {1'b1, mq[i].data};
    if (ov && oreg.rd == rs) return {1'b1, oreg.data};
`endif
    return '0;
  endfunction

  task automatic model_edge();
    bit   acc;
    ent_t e;
    acc = wb_valid && (mq.size() < DEPTH);
    if (mq.size() > 0) begin
      e    = mq.pop_front();
      ov   = 1;
      oreg = e;
    end else begin
      ov = 0;
    end
    if (acc && wb_rd != 5'd0) begin
      mq.push_back({wb_rd, wb_data});
      exp_q.push_back({wb_rd, wb_data});
    end
  endtask

  task automatic step(input bit v, input logic [4:0] rd,
                      input logic [31:0] d, input logic [4:0] r1,
                      input logic [4:0] r2);
    wb_valid = v;
    wb_rd    = rd;
    wb_data  = d;
    fwd_rs1  = r1;
    fwd_rs2  = r2;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] r1,
                      input logic [4:0] r2);
    for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, r1, r2);
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
           $urandom, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(wb_ready), 64'd1);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_wrnum", 64'(WriteRegNum), 64'd0);
    chk("rst_wrdata", 64'(WriteRegData), 64'd0);
    mq.delete();
    exp_q.delete();
    ov   = 0;
    oreg = '0;
    wb_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Monitor: cycle-level checks and commit scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [32:0] f1, f2;
      ent_t e;
      chk("wb_ready", 64'(wb_ready), 64'(mq.size() < DEPTH));
      chk("count", 64'(count), 64'(mq.size()));
      chk("pending", 64'(pending), 64'(mq.size() != 0 || ov));
      chk("regwrite", 64'(RegWrite), 64'(ov));
      if (RegWrite) begin
        if (exp_q.size() == 0) begin
          chk("commit_unexpected", 64'(WriteRegNum), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("commit_rd", 64'(WriteRegNum), 64'(e.rd));
          chk("commit_data", 64'(WriteRegData), 64'(e.data));
        end
      end
      f1 = ref_fwd(fwd_rs1);
      f2 = ref_fwd(fwd_rs2);
      chk("fwd1", 64'({fwd_hit1, fwd_data1}), 64'(f1));
      chk("fwd2", 64'({fwd_hit2, fwd_data2}), 64'(f2));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("init_regwrite", 64'(RegWrite), 64'd0);
    chk("init_count", 64'(count), 64'd0);
    chk("init_ready", 64'(wb_ready), 64'd1);
    chk("init_pending", 64'(pending), 64'd0);
    chk("init_hit", 64'({fwd_hit1, fwd_hit2}), 64'd0);
    chk("init_wrnum", 64'(WriteRegNum), 64'd0);
    rst_n  = 1;
    chk_en = 1;

    step(1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd1);
    idle(4, 5'd5, 5'd0);

    step(1, 5'd0, 32'h1234, 5'd0, 5'd0);
    idle(3, 5'd0, 5'd0);

    step(1, 5'd3, 32'h1, 5'd3, 5'd3);
    step(1, 5'd3, 32'h2, 5'd3, 5'd3);
    idle(4, 5'd3, 5'd3);

    for (int i = 0; i < 8; i++)
      step(1, 5'(i + 1), 32'hA000_0000 + i, 5'(i), 5'(i + 1));
    idle(4, 5'd8, 5'd7);

    step(1, 5'd7, 32'h77, 5'd7, 5'd7);
    idle(3, 5'd7, 5'd7);

    for (int i = 0; i < 3; i++)
      step(1, 5'(i + 10), 32'hB0 + i, 5'd10, 5'd11);
    mid_reset();
    idle(4, 5'd10, 5'd11);

    rand_steps(300);
    mid_reset();
    rand_steps(200);
    idle(6, 5'd1, 5'd2);

    chk_en = 0;
    chk("drained", 64'(exp_q.size()), 64'd0);
    chk("final_count", 64'(count), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
